// File: rtl/pwr_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_ctrl_pkg
// Description : Shared types and constants for the power sequencing controller:
//               sequencer state encoding, shutdown sub-steps, fault codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pwr_seq_ctrl_pkg;

    localparam int TMR_W = 24;

    // Sequencer states; the numeric values are visible on seq_state
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECHG  = 3'd1,
        ST_RELAY   = 3'd2,
        ST_PFC_ST  = 3'd3,
        ST_DCDC_ST = 3'd4,
        ST_RUN     = 3'd5,
        ST_SHUTDN  = 3'd6,
        ST_FAULT   = 3'd7
    } seq_state_t;

    // Shutdown sub-steps: which stage is still on and waiting for its turn-off
    typedef enum logic [1:0] {
        SD_PFC   = 2'd0,   // dcdc off, pfc and relay still on
        SD_RELAY = 2'd1,   // pfc off, relay still on
        SD_END   = 2'd2    // nothing on, leave for IDLE
    } sd_step_t;

    // Latched fault causes
    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_PFC_TMO  = 2'd1;
    localparam logic [1:0] FC_DCDC_TMO = 2'd2;
    localparam logic [1:0] FC_HARD     = 2'd3;

endpackage : pwr_seq_ctrl_pkg
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : 24-bit loadable down-counter. Counts to zero and holds there;
//               'expired' is high whenever the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer
    import pwr_seq_ctrl_pkg::*;
(
    input  logic             clk_in,
    input  logic             rstn_i,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] r_cnt;

    // Load has priority; otherwise decrement until zero
    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule : seq_timer
`default_nettype wire

// File: rtl/pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_ctrl
// Description : Power-up / power-down sequencer for an inrush relay, a PFC
//               stage and a DC-DC stage, with timeouts, ordered shutdown and
//               a latched fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_seq_ctrl
    import pwr_seq_ctrl_pkg::*;
#(
    parameter logic [23:0] PRECHG_CYC = 24'd100000,
    parameter logic [23:0] RELAY_CYC  = 24'd20000,
    parameter logic [23:0] PFC_TMO    = 24'd500000,
    parameter logic [23:0] DCDC_TMO   = 24'd500000,
    parameter logic [23:0] OFF_DLY    = 24'd10000
)(
    input  logic       clk_in,
    input  logic       rstn_i,
    input  logic       sw_state,
    input  logic       pfc_ok,
    input  logic       dcdc_ok,
    input  logic       fault_in,
    output logic       relay_en,
    output logic       pfc_en,
    output logic       dcdc_en,
    output logic [2:0] seq_state,
    output logic [1:0] fault_code
);

    // A gap loaded with N would give N+1 cycles between turn-offs, because the
    // step change happens on the edge after the counter reaches zero.
    localparam logic [23:0] C_OFF_GAP = (OFF_DLY == 24'd0) ? 24'd0 : (OFF_DLY - 24'd1);

    logic       r_pfc_meta, r_pfc_sync;
    logic       r_dcdc_meta, r_dcdc_sync;
    logic       r_flt_meta, r_flt_sync;
    logic       r_sw_armed;
    seq_state_t r_state, w_state_nxt;
    sd_step_t   r_sd, w_sd_nxt;
    logic [1:0] r_fault_code, w_fc_nxt;
    logic       r_relay_en, r_pfc_en, r_dcdc_en;
    logic       w_relay_nxt, w_pfc_nxt, w_dcdc_nxt;
    logic       w_load;
    logic [23:0] w_load_val;
    logic       w_expired;

    seq_timer u_timer (
        .clk_in   (clk_in),
        .rstn_i   (rstn_i),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pfc_meta  <= 1'b0;
            r_pfc_sync  <= 1'b0;
            r_dcdc_meta <= 1'b0;
            r_dcdc_sync <= 1'b0;
            r_flt_meta  <= 1'b0;
            r_flt_sync  <= 1'b0;
        end else begin
            r_pfc_meta  <= pfc_ok;
            r_pfc_sync  <= r_pfc_meta;
            r_dcdc_meta <= dcdc_ok;
            r_dcdc_sync <= r_dcdc_meta;
            r_flt_meta  <= fault_in;
            r_flt_sync  <= r_flt_meta;
        end
    end

    // A start needs sw_state seen low at least once since reset, so a switch
    // left on through a reset does not relaunch the sequence by itself.
    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sw_armed <= 1'b0;
        end else if (!sw_state) begin
            r_sw_armed <= 1'b1;
        end
    end

    // State, shutdown sub-step, fault code and enable registers
    always_ff @(posedge clk_in or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_sd         <= SD_END;
            r_fault_code <= FC_NONE;
            r_relay_en   <= 1'b0;
            r_pfc_en     <= 1'b0;
            r_dcdc_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sd         <= w_sd_nxt;
            r_fault_code <= w_fc_nxt;
            r_relay_en   <= w_relay_nxt;
            r_pfc_en     <= w_pfc_nxt;
            r_dcdc_en    <= w_dcdc_nxt;
        end
    end

    // Next-state logic; fault_in first, then switch-off, then stage progress
    always_comb begin
        w_state_nxt = r_state;
        w_sd_nxt    = r_sd;
        w_fc_nxt    = r_fault_code;
        w_load      = 1'b0;
        w_load_val  = 24'd0;
        case (r_state)
            ST_IDLE: begin
                if (sw_state && r_sw_armed) begin
                    w_state_nxt = ST_PRECHG;
                    w_load      = 1'b1;
                    w_load_val  = PRECHG_CYC;
                end
            end
            ST_FAULT: begin
                if (!sw_state && !r_flt_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_fc_nxt    = FC_NONE;
                    w_load      = 1'b1;
                end
            end
            default: begin
                if (r_flt_sync) begin
                    w_state_nxt = ST_FAULT;
                    w_fc_nxt    = FC_HARD;
                    w_load      = 1'b1;
                end else if (!sw_state && (r_state != ST_SHUTDN)) begin
                    // Start shutdown at the highest stage that is actually on
                    w_state_nxt = ST_SHUTDN;
                    w_load      = 1'b1;
                    if (r_pfc_en) begin
                        w_sd_nxt   = SD_PFC;
                        w_load_val = C_OFF_GAP;
                    end else if (r_relay_en) begin
                        w_sd_nxt   = SD_RELAY;
                        w_load_val = C_OFF_GAP;
                    end else begin
                        w_sd_nxt   = SD_END;
                    end
                end else begin
                    case (r_state)
                        ST_PRECHG: begin
                            if (w_expired) begin
                                w_state_nxt = ST_RELAY;
                                w_load      = 1'b1;
                                w_load_val  = RELAY_CYC;
                            end
                        end
                        ST_RELAY: begin
                            if (w_expired) begin
                                w_state_nxt = ST_PFC_ST;
                                w_load      = 1'b1;
                                w_load_val  = PFC_TMO;
                            end
                        end
                        ST_PFC_ST: begin
                            if (r_pfc_sync) begin
                                w_state_nxt = ST_DCDC_ST;
                                w_load      = 1'b1;
                                w_load_val  = DCDC_TMO;
                            end else if (w_expired) begin
                                w_state_nxt = ST_FAULT;
                                w_fc_nxt    = FC_PFC_TMO;
                                w_load      = 1'b1;
                            end
                        end
                        ST_DCDC_ST: begin
                            if (r_dcdc_sync) begin
                                w_state_nxt = ST_RUN;
                                w_load      = 1'b1;
                            end else if (w_expired) begin
                                w_state_nxt = ST_FAULT;
                                w_fc_nxt    = FC_DCDC_TMO;
                                w_load      = 1'b1;
                            end
                        end
                        ST_RUN: begin
                            if (!r_pfc_sync || !r_dcdc_sync) begin
                                w_state_nxt = ST_FAULT;
                                w_fc_nxt    = FC_HARD;
                                w_load      = 1'b1;
                            end
                        end
                        ST_SHUTDN: begin
                            case (r_sd)
                                SD_PFC: begin
                                    if (w_expired) begin
                                        w_sd_nxt   = SD_RELAY;
                                        w_load     = 1'b1;
                                        w_load_val = C_OFF_GAP;
                                    end
                                end
                                SD_RELAY: begin
                                    if (w_expired) begin
                                        w_state_nxt = ST_IDLE;
                                        w_load      = 1'b1;
                                    end
                                end
                                default: begin
                                    w_state_nxt = ST_IDLE;
                                    w_load      = 1'b1;
                                end
                            endcase
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Enables decoded from the upcoming state so they switch with the state
    always_comb begin
        w_relay_nxt = 1'b0;
        w_pfc_nxt   = 1'b0;
        w_dcdc_nxt  = 1'b0;
        case (w_state_nxt)
            ST_RELAY: begin
                w_relay_nxt = 1'b1;
            end
            ST_PFC_ST: begin
                w_relay_nxt = 1'b1;
                w_pfc_nxt   = 1'b1;
            end
            ST_DCDC_ST, ST_RUN: begin
                w_relay_nxt = 1'b1;
                w_pfc_nxt   = 1'b1;
                w_dcdc_nxt  = 1'b1;
            end
            ST_SHUTDN: begin
                w_relay_nxt = (w_sd_nxt == SD_PFC) || (w_sd_nxt == SD_RELAY);
                w_pfc_nxt   = (w_sd_nxt == SD_PFC);
            end
            default: begin
                w_relay_nxt = 1'b0;
            end
        endcase
    end

    assign relay_en   = r_relay_en;
    assign pfc_en     = r_pfc_en;
    assign dcdc_en    = r_dcdc_en;
    assign seq_state  = r_state;
    assign fault_code = r_fault_code;

endmodule : pwr_seq_ctrl
`default_nettype wire

// File: tb/tb_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwr_seq_ctrl
// Description : Directed self-checking bench for pwr_seq_ctrl with short
//               timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_seq_ctrl;

    localparam logic [23:0] P_PRE  = 24'd20;
    localparam logic [23:0] P_REL  = 24'd10;
    localparam logic [23:0] P_PFC  = 24'd50;
    localparam logic [23:0] P_DCDC = 24'd50;
    localparam logic [23:0] P_OFF  = 24'd5;

    logic       clk_in = 1'b0;
    logic       rstn_i;
    logic       sw_state;
    logic       pfc_ok;
    logic       dcdc_ok;
    logic       fault_in;
    logic       relay_en;
    logic       pfc_en;
    logic       dcdc_en;
    logic [2:0] seq_state;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    pwr_seq_ctrl #(
        .PRECHG_CYC (P_PRE),
        .RELAY_CYC  (P_REL),
        .PFC_TMO    (P_PFC),
        .DCDC_TMO   (P_DCDC),
        .OFF_DLY    (P_OFF)
    ) dut (
        .clk_in     (clk_in),
        .rstn_i     (rstn_i),
        .sw_state   (sw_state),
        .pfc_ok     (pfc_ok),
        .dcdc_ok    (dcdc_ok),
        .fault_in   (fault_in),
        .relay_en   (relay_en),
        .pfc_en     (pfc_en),
        .dcdc_en    (dcdc_en),
        .seq_state  (seq_state),
        .fault_code (fault_code)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return relay_en;
            1:       return pfc_en;
            default: return dcdc_en;
        endcase
    endfunction

    // Negedges until enable 'sel' equals val; -1 and a failure on timeout
    task automatic wait_sig(input string tag, input int sel, input logic val,
                            input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk_in);
            n++;
            if (sel_sig(sel) === val) return;
        end
        check_val({tag, "_timeout"}, 0, 1);
        n = -1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st,
                              input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk_in);
            n++;
            if (seq_state === st) return;
        end
        check_val({tag, "_timeout"}, 0, 1);
        n = -1;
    endtask

    // Enable chain ordering must hold on every cycle out of reset
    always @(negedge clk_in) begin
        if (rstn_i === 1'b1)
            check_val("enable_order",
                      32'((!dcdc_en || pfc_en) && (!pfc_en || relay_en)), 1);
    end

    initial begin
        #300000;
        check_val("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_i = 1'b0; sw_state = 1'b0; pfc_ok = 1'b0; dcdc_ok = 1'b0; fault_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_val("rst_state", seq_state, 0);
        check_val("rst_enables", {relay_en, pfc_en, dcdc_en}, 0);
        check_val("rst_fcode", fault_code, 0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_in);

        // Normal start: sampled edge + PRECHG_CYC + 1 to relay, RELAY_CYC + 1 to pfc
        sw_state = 1'b1;
        wait_sig("relay_rise", 0, 1'b1, 100, cnt);
        check_val("relay_delay", cnt - 1, 21);
        check_val("relay_state", seq_state, 2);
        wait_sig("pfc_rise", 1, 1'b1, 100, cnt);
        check_val("pfc_delay", cnt, 11);
        check_val("pfc_state", seq_state, 3);
        repeat (10) @(negedge clk_in);
        pfc_ok = 1'b1;
        // two synchronizer flops plus the state register
        wait_sig("dcdc_rise", 2, 1'b1, 20, cnt);
        check_val("dcdc_delay", cnt, 3);
        check_val("dcdc_state", seq_state, 4);
        repeat (10) @(negedge clk_in);
        dcdc_ok = 1'b1;
        wait_state("run", 3'd5, 20, cnt);
        check_val("run_delay", cnt, 3);
        check_val("run_enables", {relay_en, pfc_en, dcdc_en}, 3'b111);

        // Ordered shutdown
        sw_state = 1'b0;
        wait_sig("sd_dcdc_fall", 2, 1'b0, 10, cnt);
        check_val("sd_dcdc_delay", cnt, 1);
        check_val("sd_state", seq_state, 6);
        check_val("sd_pfc_still_on", pfc_en, 1);
        wait_sig("sd_pfc_fall", 1, 1'b0, 20, cnt);
        check_val("sd_pfc_gap", cnt, 5);
        wait_sig("sd_relay_fall", 0, 1'b0, 20, cnt);
        check_val("sd_relay_gap", cnt, 5);
        check_val("sd_idle", seq_state, 0);

        // PFC timeout: fault on the edge after the 50-cycle timer reaches zero
        pfc_ok = 1'b0; dcdc_ok = 1'b0;
        repeat (3) @(negedge clk_in);
        sw_state = 1'b1;
        wait_sig("tmo_pfc_rise", 1, 1'b1, 100, cnt);
        wait_state("tmo_fault", 3'd7, 100, cnt);
        check_val("tmo_delay", cnt, 51);
        check_val("tmo_fcode", fault_code, 1);
        check_val("tmo_enables", {relay_en, pfc_en, dcdc_en}, 0);
        repeat (20) @(negedge clk_in);
        check_val("tmo_hold", seq_state, 7);
        sw_state = 1'b0;
        wait_state("tmo_exit", 3'd0, 5, cnt);
        check_val("tmo_exit_delay", cnt, 1);
        check_val("tmo_fcode_clr", fault_code, 0);

        // Loss of good in RUN (goods already high before their stages: ignored early)
        pfc_ok = 1'b1; dcdc_ok = 1'b1;
        repeat (2) @(negedge clk_in);
        sw_state = 1'b1;
        wait_sig("log_relay_rise", 0, 1'b1, 100, cnt);
        check_val("log_relay_delay", cnt - 1, 21);
        wait_state("log_run", 3'd5, 100, cnt);
        pfc_ok = 1'b0;
        wait_sig("log_relay_fall", 0, 1'b0, 10, cnt);
        check_val("log_delay", cnt, 3);
        check_val("log_enables", {relay_en, pfc_en, dcdc_en}, 0);
        check_val("log_fcode", fault_code, 3);
        sw_state = 1'b0;
        wait_state("log_exit", 3'd0, 5, cnt);
        check_val("log_fcode_clr", fault_code, 0);

        // fault_in and sw_state drop reach the FSM on the same edge in DCDC_ST
        pfc_ok = 1'b1; dcdc_ok = 1'b0;
        repeat (2) @(negedge clk_in);
        sw_state = 1'b1;
        wait_state("sim_dcdc", 3'd4, 100, cnt);
        fault_in = 1'b1;
        repeat (2) @(negedge clk_in);
        sw_state = 1'b0;
        @(negedge clk_in);
        check_val("sim_state", seq_state, 7);
        check_val("sim_fcode", fault_code, 3);
        check_val("sim_enables", {relay_en, pfc_en, dcdc_en}, 0);
        fault_in = 1'b0;
        wait_state("sim_exit", 3'd0, 10, cnt);

        // Reset during RUN with the switch left on
        dcdc_ok = 1'b1;
        repeat (2) @(negedge clk_in);
        sw_state = 1'b1;
        wait_state("rst_run", 3'd5, 100, cnt);
        rstn_i = 1'b0;
        #1;
        check_val("arst_enables", {relay_en, pfc_en, dcdc_en}, 0);
        check_val("arst_state", seq_state, 0);
        @(negedge clk_in);
        rstn_i = 1'b1;
        repeat (30) @(negedge clk_in);
        check_val("no_restart_state", seq_state, 0);
        check_val("no_restart_relay", relay_en, 0);
        sw_state = 1'b0;
        repeat (2) @(negedge clk_in);
        sw_state = 1'b1;
        wait_sig("restart_relay", 0, 1'b1, 100, cnt);
        check_val("restart_delay", cnt - 1, 21);

        // Switch-off from RELAY, then abort during PRECHG (nothing on: one SHUTDN cycle)
        sw_state = 1'b0;
        wait_state("abort_rel_idle", 3'd0, 50, cnt);
        check_val("abort_rel_delay", cnt, 6);
        sw_state = 1'b1;
        repeat (5) @(negedge clk_in);
        check_val("abort_pre_state", seq_state, 1);
        sw_state = 1'b0;
        wait_state("abort_pre_idle", 3'd0, 5, cnt);
        check_val("abort_pre_delay", cnt, 2);
        check_val("abort_pre_relay", relay_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pwr_seq_ctrl
`default_nettype wire
